// File: rtl/sram_req_arbiter.sv
// Purpose: shares one sram-like memory port between the inst-fetch and load/store masters.
// Latency: zero added cycles on both the request and the response path (both are combinational).
// Backpressure: a request waits on mem_addr_ok; new requests are refused while the owner queue is full.
//
// Ports:
//   clk, reset              - single clock, synchronous active-high reset
//   inst_* / data_*         - upstream sram-like master ports (req/wr/size/wstrb/addr/wdata in,
//                             addr_ok/data_ok/rdata out)
//   mem_*                   - downstream sram-like port (req/wr/size/wstrb/addr/wdata out,
//                             addr_ok/data_ok/rdata in)
//   resp_err                - sticky: a mem_data_ok arrived with nothing outstanding
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        resp_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       hold_owner;
    logic                       hold_owner_next;
    logic                       owner;

    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       head_owner;

    // Pointers wrap at MAX_OUTSTANDING explicitly so MAX=1 also works.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Registered count only: a pop in this cycle never frees room for a push.
    assign full = (count == CW'(MAX_OUTSTANDING));

    always_comb begin
        state_next      = state;
        hold_owner_next = hold_owner;
        owner           = OWN_INST;
        mem_req         = 1'b0;
        case (state)
            IDLE: begin
                owner   = data_req ? OWN_DATA : OWN_INST;
                mem_req = (data_req | inst_req) & ~full;
                if (mem_req && !mem_addr_ok) begin
                    state_next      = HOLD;
                    hold_owner_next = owner;
                end
            end
            HOLD: begin
                // The held master keeps the port even if the other raises req;
                // the queue had room when the hold began and cannot fill meanwhile.
                owner   = hold_owner;
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            mem_req = 1'b0;
        end
    end

    assign mem_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (owner == OWN_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (owner == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & (count != '0) & ~reset;

    assign inst_addr_ok = push & (owner == OWN_INST);
    assign data_addr_ok = push & (owner == OWN_DATA);

    assign head_owner   = owner_q[rptr];
    assign inst_data_ok = pop & (head_owner == OWN_INST);
    assign data_data_ok = pop & (head_owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_owner <= OWN_INST;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            hold_owner <= hold_owner_next;
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A response with nothing outstanding is dropped and flagged.
            if (mem_data_ok && (count == '0)) begin
                resp_err <= 1'b1;
            end
        end
    end

    // Queue payload needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            owner_q[wptr] <= owner;
        end
    end

endmodule
